// File: rtl/gx_rst_ctrl_pkg.sv
// Shared types and helpers for the single-channel transceiver reset sequencer.
package gx_rst_ctrl_pkg;

    typedef enum logic [1:0] {TX_ANALOG, TX_WAIT, TX_DLY, TX_READY} tx_state_t;
    typedef enum logic [1:0] {RX_ANALOG, RX_WAIT, RX_LTD, RX_READY} rx_state_t;

    // One counter width serves every timed phase of both sequences.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/gx_rst_ctrl_sync.sv
// Multi-flop synchroniser for one asynchronous status bit from the transceiver.
// Latency STAGES clk cycles; no backpressure.
module gx_rst_ctrl_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/gx_std_x1_rst_ctrl.sv
// Reset sequencer for one standard-PCS transceiver channel: independent TX and RX sequences.
// Outputs registered, decoded from state; loss of lock re-enters the sequence past analog reset.
module gx_std_x1_rst_ctrl
    import gx_rst_ctrl_pkg::*;
#(
    parameter int ANALOG_HOLD   = 70,
    parameter int DIGITAL_DELAY = 20,
    parameter int LTD_STABLE    = 1000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tx_reset_req,
    input  logic rx_reset_req,
    input  logic tx_pll_locked,
    input  logic tx_cal_busy,
    input  logic rx_cal_busy,
    input  logic rx_is_lockedtodata,
    output logic tx_analogreset,
    output logic tx_digitalreset,
    output logic rx_analogreset,
    output logic rx_digitalreset,
    output logic tx_ready,
    output logic rx_ready
);

    localparam int CW = cnt_width(ANALOG_HOLD, DIGITAL_DELAY, LTD_STABLE);
    localparam logic [CW-1:0] AH_LAST  = CW'(ANALOG_HOLD - 1);
    localparam logic [CW-1:0] DD_LAST  = CW'(DIGITAL_DELAY - 1);
    localparam logic [CW-1:0] LTD_LAST = CW'(LTD_STABLE - 1);

    logic pll_s, tx_busy_s, rx_busy_s, ltd_s;

    gx_rst_ctrl_sync #(.STAGES(SYNC_STAGES)) u_sync_pll (.clk(clk), .reset(reset), .d(tx_pll_locked),      .q(pll_s));
    gx_rst_ctrl_sync #(.STAGES(SYNC_STAGES)) u_sync_txb (.clk(clk), .reset(reset), .d(tx_cal_busy),        .q(tx_busy_s));
    gx_rst_ctrl_sync #(.STAGES(SYNC_STAGES)) u_sync_rxb (.clk(clk), .reset(reset), .d(rx_cal_busy),        .q(rx_busy_s));
    gx_rst_ctrl_sync #(.STAGES(SYNC_STAGES)) u_sync_ltd (.clk(clk), .reset(reset), .d(rx_is_lockedtodata), .q(ltd_s));

    tx_state_t        tx_state_q, tx_state_d;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
    logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
    logic             tx_ok;

    assign tx_ok = pll_s & ~tx_busy_s;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        if (tx_reset_req) begin
            tx_state_d = TX_ANALOG;
            tx_cnt_d   = '0;
        end else begin
            unique case (tx_state_q)
                TX_ANALOG: begin
                    if (tx_cnt_q == AH_LAST) begin
                        tx_state_d = TX_WAIT;
                        tx_cnt_d   = '0;
                    end else begin
                        tx_cnt_d = tx_cnt_q + CW'(1);
                    end
                end
                TX_WAIT: begin
                    if (tx_ok) begin
                        tx_state_d = TX_DLY;
                        tx_cnt_d   = '0;
                    end
                end
                TX_DLY: begin
                    // A failing condition wins over a completing count.
                    if (!tx_ok) begin
                        tx_state_d = TX_WAIT;
                        tx_cnt_d   = '0;
                    end else if (tx_cnt_q == DD_LAST) begin
                        tx_state_d = TX_READY;
                        tx_cnt_d   = '0;
                    end else begin
                        tx_cnt_d = tx_cnt_q + CW'(1);
                    end
                end
                TX_READY: begin
                    if (!pll_s) begin
                        tx_state_d = TX_WAIT;
                        tx_cnt_d   = '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        if (rx_reset_req) begin
            rx_state_d = RX_ANALOG;
            rx_cnt_d   = '0;
        end else begin
            unique case (rx_state_q)
                RX_ANALOG: begin
                    if (rx_cnt_q == AH_LAST) begin
                        rx_state_d = RX_WAIT;
                        rx_cnt_d   = '0;
                    end else begin
                        rx_cnt_d = rx_cnt_q + CW'(1);
                    end
                end
                RX_WAIT: begin
                    if (!rx_busy_s) begin
                        rx_state_d = RX_LTD;
                        rx_cnt_d   = '0;
                    end
                end
                RX_LTD: begin
                    // Count only an unbroken run of lock-to-data.
                    if (rx_busy_s) begin
                        rx_state_d = RX_WAIT;
                        rx_cnt_d   = '0;
                    end else if (!ltd_s) begin
                        rx_cnt_d = '0;
                    end else if (rx_cnt_q == LTD_LAST) begin
                        rx_state_d = RX_READY;
                        rx_cnt_d   = '0;
                    end else begin
                        rx_cnt_d = rx_cnt_q + CW'(1);
                    end
                end
                RX_READY: begin
                    if (!ltd_s) begin
                        rx_state_d = RX_LTD;
                        rx_cnt_d   = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q      <= TX_ANALOG;
            tx_cnt_q        <= '0;
            tx_analogreset  <= 1'b1;
            tx_digitalreset <= 1'b1;
            tx_ready        <= 1'b0;
        end else begin
            tx_state_q      <= tx_state_d;
            tx_cnt_q        <= tx_cnt_d;
            tx_analogreset  <= (tx_state_d == TX_ANALOG);
            tx_digitalreset <= (tx_state_d != TX_READY);
            tx_ready        <= (tx_state_d == TX_READY);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q      <= RX_ANALOG;
            rx_cnt_q        <= '0;
            rx_analogreset  <= 1'b1;
            rx_digitalreset <= 1'b1;
            rx_ready        <= 1'b0;
        end else begin
            rx_state_q      <= rx_state_d;
            rx_cnt_q        <= rx_cnt_d;
            rx_analogreset  <= (rx_state_d == RX_ANALOG);
            rx_digitalreset <= (rx_state_d != RX_READY);
            rx_ready        <= (rx_state_d == RX_READY);
        end
    end

endmodule
